// File: rtl/decode_4b16_pkg.sv
// Shared constants, one-hot vector type and decode helper for decode_4b16.
package decode_4b16_pkg;

  localparam int DEC_SEL_W = 4;
  localparam int DEC_OUT_N = 16;

  typedef logic [DEC_OUT_N-1:0] dec_vec_t;

  localparam dec_vec_t DEC_NONE = '0;

  function automatic dec_vec_t dec_onehot(input logic [DEC_SEL_W-1:0] sel);
    dec_vec_t vec;
    vec = DEC_NONE;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decode_4b16_core.sv
// Pure combinational decode of a 4-bit select plus enable into a one-hot vector.
module decode_4b16_core
  import decode_4b16_pkg::*;
(
  input  logic [DEC_SEL_W-1:0] sel,
  input  logic                 en,
  output dec_vec_t             vec
);

  always_comb begin
    vec = DEC_NONE;
    if (en) begin
      vec = dec_onehot(sel);
    end
  end

endmodule

// File: rtl/decode_4b16.sv
// Registered 4-to-16 one-hot decoder with enable; scalar strobes O0..O15.
// Optional registered Valid output enabled by defining DECODE_4B16_VALID_EN.
module decode_4b16
  import decode_4b16_pkg::*;
(
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [DEC_SEL_W-1:0] A,
  input  logic                 Enable,
  output logic                 O0,
  output logic                 O1,
  output logic                 O2,
  output logic                 O3,
  output logic                 O4,
  output logic                 O5,
  output logic                 O6,
  output logic                 O7,
  output logic                 O8,
  output logic                 O9,
  output logic                 O10,
  output logic                 O11,
  output logic                 O12,
  output logic                 O13,
  output logic                 O14,
  output logic                 O15
`ifdef DECODE_4B16_VALID_EN
  ,
  output logic                 Valid
`endif
);

  dec_vec_t next_vec;
  dec_vec_t out_q;

  decode_4b16_core u_core (
    .sel (A),
    .en  (Enable),
    .vec (next_vec)
  );

  // Outputs come only from this register, so no input-to-output combinational path.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_q <= DEC_NONE;
    end else begin
      out_q <= next_vec;
    end
  end

`ifdef DECODE_4B16_VALID_EN
  logic valid_q;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= |next_vec;
    end
  end

  assign Valid = valid_q;
`endif

  assign O0  = out_q[0];
  assign O1  = out_q[1];
  assign O2  = out_q[2];
  assign O3  = out_q[3];
  assign O4  = out_q[4];
  assign O5  = out_q[5];
  assign O6  = out_q[6];
  assign O7  = out_q[7];
  assign O8  = out_q[8];
  assign O9  = out_q[9];
  assign O10 = out_q[10];
  assign O11 = out_q[11];
  assign O12 = out_q[12];
  assign O13 = out_q[13];
  assign O14 = out_q[14];
  assign O15 = out_q[15];

endmodule

// File: tb/tb_decode_4b16.sv
// Self-checking bench for decode_4b16: table-driven vectors through a scoreboard queue,
// plus hand-written sequences; checks Valid when DECODE_4B16_VALID_EN is defined.
module tb_decode_4b16;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] A;
  logic       Enable;
  logic O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, O10, O11, O12, O13, O14, O15;
`ifdef DECODE_4B16_VALID_EN
  logic Valid;
`endif

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  a;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];

  always #5 CLK = ~CLK;

  decode_4b16 dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .A      (A),
    .Enable (Enable),
    .O0 (O0), .O1 (O1), .O2 (O2), .O3 (O3),
    .O4 (O4), .O5 (O5), .O6 (O6), .O7 (O7),
    .O8 (O8), .O9 (O9), .O10 (O10), .O11 (O11),
    .O12 (O12), .O13 (O13), .O14 (O14), .O15 (O15)
`ifdef DECODE_4B16_VALID_EN
    ,
    .Valid  (Valid)
`endif
  );

  function automatic logic [15:0] outs();
    return {O15, O14, O13, O12, O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0};
  endfunction

  function automatic logic [15:0] bit16(input int x);
    logic [15:0] v;
    v = 16'h0001;
    return v << x;
  endfunction

  task automatic addVec(input logic rst, input logic en, input logic [3:0] a,
                        input logic [15:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.en = en; v.a = a; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic checkOutput();
    sb_t item;
    logic [15:0] got;
    got = outs();
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $display("[TB] FAIL scoreboard_empty: got %h, no expected entry", got);
      return;
    end
    item = sb.pop_front();
    if (got !== item.exp) begin
      failed++;
      $display("[TB] FAIL %s: outputs %h, expected %h", item.name, got, item.exp);
    end
    tests++;
    if ($countones(got) > 1 || $isunknown(got)) begin
      failed++;
      $display("[TB] FAIL %s_onehot: outputs %h are multi-hot or unknown", item.name, got);
    end
`ifdef DECODE_4B16_VALID_EN
    tests++;
    if (Valid !== (|item.exp) || Valid !== (|got)) begin
      failed++;
      $display("[TB] FAIL %s_valid: Valid %b, expected %b", item.name, Valid, |item.exp);
    end
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] a,
                               input logic [15:0] exp, input string name);
    sb_t item;
    @(negedge CLK);
    Reset = rst;
    Enable = en;
    A = a;
    if (en && $isunknown(a)) begin
      tests++;
      failed++;
      $display("[TB] FAIL %s_xsel: A %b unknown while Enable=1", name, a);
    end
    item.exp = exp;
    item.name = name;
    sb.push_back(item);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    Enable = 1'b0;
    A = 4'd0;

    // Reset hold and release, full sweep, enable gating
    addVec(1'b1, 1'b1, 4'd5, 16'h0000, "reset_hold0");
    addVec(1'b1, 1'b1, 4'd5, 16'h0000, "reset_hold1");
    addVec(1'b0, 1'b1, 4'd5, 16'h0020, "reset_release");
    for (int i = 0; i < 16; i++)
      addVec(1'b0, 1'b1, 4'(i), bit16(i), $sformatf("sweep_a%0d", i));
    addVec(1'b0, 1'b0, 4'd10, 16'h0000, "gate_off");
    addVec(1'b0, 1'b0, 4'd10, 16'h0000, "gate_off2");
    addVec(1'b0, 1'b1, 4'd10, 16'h0400, "gate_on");
    addVec(1'b0, 1'b0, 4'd10, 16'h0000, "gate_deassert");

    // Mid-stream reset pulse at A=7
    addVec(1'b0, 1'b1, 4'd5, 16'h0020, "mid_a5");
    addVec(1'b0, 1'b1, 4'd6, 16'h0040, "mid_a6");
    addVec(1'b1, 1'b1, 4'd7, 16'h0000, "mid_reset_a7");
    addVec(1'b0, 1'b1, 4'd8, 16'h0100, "mid_a8");
    addVec(1'b0, 1'b1, 4'd9, 16'h0200, "mid_a9");

    // Back-to-back 3/12 toggle
    for (int i = 0; i < 6; i++)
      addVec(1'b0, 1'b1, (i % 2 == 0) ? 4'd3 : 4'd12,
             (i % 2 == 0) ? 16'h0008 : 16'h1000, $sformatf("toggle%0d", i));

    for (int i = 0; i < tbl.size(); i++)
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].exp, tbl[i].name);

    // Inputs changing between edges must not reach the outputs
    applyStimulus(1'b0, 1'b1, 4'd2, 16'h0004, "hold_a2");
    A = 4'd9;
    Enable = 1'b0;
    #2;
    tests++;
    if (outs() !== 16'h0004) begin
      failed++;
      $display("[TB] FAIL midcycle_change: outputs %h, expected %h", outs(), 16'h0004);
    end
    applyStimulus(1'b0, 1'b1, 4'd9, 16'h0200, "after_midcycle");

    // Enable and reset both asserted: reset wins, then O15 decodes on release
    applyStimulus(1'b1, 1'b1, 4'd15, 16'h0000, "reset_over_enable");
    applyStimulus(1'b0, 1'b1, 4'd15, 16'h8000, "release_a15");
    applyStimulus(1'b0, 1'b1, 4'd0, 16'h0001, "wrap_a0");

    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
